// File: rtl/axi_crossbar_rd_decerr.sv
// rtl/axi_crossbar_rd_decerr.sv - DECERR read responder for unmapped crossbar reads
// Answers each decode-error command with len+1 zero-data DECERR beats, then a completion pulse.
module axi_crossbar_rd_decerr #(
   parameter int ID_WIDTH   = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   s_cmd_id,
   input  logic [7:0]            s_cmd_len,
   input  logic                  s_cmd_decerr,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   output logic [ID_WIDTH-1:0]   m_axi_rid,
   output logic [DATA_WIDTH-1:0] m_axi_rdata,
   output logic [1:0]            m_axi_rresp,
   output logic                  m_axi_rlast,
   output logic                  m_axi_rvalid,
   input  logic                  m_axi_rready,
   output logic [ID_WIDTH-1:0]   m_cpl_id,
   output logic                  m_cpl_valid
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t     state;
   logic [7:0] beat_cnt;

   assign s_cmd_ready = (state == IDLE);
   assign m_axi_rdata = '0;
   assign m_axi_rresp = 2'b11;

   // rid/cpl_id are data-only and deliberately left out of the reset branch
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         m_axi_rvalid <= 1'b0;
         m_axi_rlast  <= 1'b0;
         m_cpl_valid  <= 1'b0;
         beat_cnt     <= 8'd0;
      end else begin
         m_cpl_valid <= 1'b0;
         case (state)
            IDLE: begin
               // Non-error commands are simply consumed here
               if (s_cmd_valid && s_cmd_decerr) begin
                  m_axi_rid    <= s_cmd_id;
                  beat_cnt     <= s_cmd_len;
                  m_axi_rlast  <= (s_cmd_len == 8'd0);
                  m_axi_rvalid <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (m_axi_rready) begin
                  if (beat_cnt == 8'd0) begin
                     m_axi_rvalid <= 1'b0;
                     m_axi_rlast  <= 1'b0;
                     m_cpl_valid  <= 1'b1;
                     m_cpl_id     <= m_axi_rid;
                     state        <= IDLE;
                  end else begin
                     beat_cnt    <= beat_cnt - 8'd1;
                     m_axi_rlast <= (beat_cnt == 8'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_crossbar_rd_decerr.md
AXI_CROSSBAR_RD_DECERR -- requirements
Module: axi_crossbar_rd_decerr

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 8, meaning width of the read ID field.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of the R data bus.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_cmd_id  input  ID_WIDTH  ARID of the decoded read.
REQ-006 SHALL have port s_cmd_len  input  8  ARLEN of the decoded read (beats minus one).
REQ-007 SHALL have port s_cmd_decerr  input  1  address decode failed.
REQ-008 SHALL have port s_cmd_valid  input  1  reply command valid (from address decoder rc output).
REQ-009 SHALL have port s_cmd_ready  output  1  reply command accepted.
REQ-010 SHALL have port m_axi_rid  output  ID_WIDTH  response ID.
REQ-011 SHALL have port m_axi_rdata  output  DATA_WIDTH  response data, constant zero.
REQ-012 SHALL have port m_axi_rresp  output  2  response code, constant 2'b11 (DECERR).
REQ-013 SHALL have port m_axi_rlast  output  1  final beat marker.
REQ-014 SHALL have port m_axi_rvalid  output  1  beat valid.
REQ-015 SHALL have port m_axi_rready  input  1  beat accepted by downstream R mux.
REQ-016 SHALL have port m_cpl_id  output  ID_WIDTH  ID of a completed error burst.
REQ-017 SHALL have port m_cpl_valid  output  1  single-cycle completion pulse.

Function
REQ-018 SHALL implement two states: IDLE and RESP; reset state IDLE.
REQ-019 SHALL drive s_cmd_ready high iff state is IDLE (combinational from state register only, no dependence on s_cmd_valid).
REQ-020 SHALL, on s_cmd_valid && s_cmd_ready with s_cmd_decerr=0, consume the command with no R beats, no completion, and remain in IDLE.
REQ-021 SHALL, on s_cmd_valid && s_cmd_ready with s_cmd_decerr=1, register id into m_axi_rid, load 8-bit beat counter with s_cmd_len, enter RESP, and assert m_axi_rvalid the next cycle (latency 1).
REQ-022 SHALL drive m_axi_rlast high in RESP iff beat counter == 0; rlast registered, valid in same cycle as the beat it marks.
REQ-023 SHALL hold m_axi_rid, m_axi_rlast, m_axi_rvalid stable while m_axi_rvalid && !m_axi_rready.
REQ-024 SHALL, on each m_axi_rvalid && m_axi_rready with counter != 0, decrement counter by 1 and keep rvalid high (back-to-back beats, one per cycle).
REQ-025 SHALL, on m_axi_rvalid && m_axi_rready with m_axi_rlast=1, deassert rvalid/rlast next cycle, return to IDLE, and pulse m_cpl_valid for exactly one cycle with m_cpl_id = burst ID.
REQ-026 SHALL emit exactly s_cmd_len+1 beats per decerr command; s_cmd_len=255 yields 256 beats with no counter wrap.
REQ-027 SHALL accept a new command in the cycle state returns to IDLE, giving one bubble cycle between consecutive error bursts.
REQ-028 SHALL keep m_axi_rdata = 0 and m_axi_rresp = 2'b11 in all cycles.
REQ-029 SHALL never assert m_axi_rvalid in IDLE nor accept a command in RESP.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, m_axi_rvalid=0, m_axi_rlast=0, m_cpl_valid=0; s_cmd_ready=1 the cycle after rst deasserts.
REQ-031 SHALL, on rst mid-burst, abandon remaining beats without asserting m_cpl_valid; m_axi_rid and m_cpl_id have no reset requirement.

Verification
REQ-032 Single-beat: decerr cmd id=0x5A len=0, rready=1 -> one beat cycle N+1, rid=0x5A, rresp=3, rlast=1; cpl_valid pulse cycle N+2 id=0x5A.
REQ-033 Non-error cmd: decerr=0 id=0x11 len=7 -> s_cmd_ready stays 1, rvalid never asserts, no cpl pulse.
REQ-034 Backpressure: len=3, rready toggled 1,0,0,1,1,0,1 -> exactly 4 accepted beats, rlast only on 4th, outputs stable during stalls.
REQ-035 Max length: len=255, rready=1 -> 256 consecutive beats, rlast on 256th only, then IDLE.
REQ-036 Back-to-back: two decerr cmds (id 0x01 len 1, id 0x02 len 0) held valid -> second accepted the cycle after first's last beat, one bubble, two cpl pulses in order.
REQ-037 Reset mid-burst: len=9, rst after 3 beats -> rvalid low next cycle, no cpl pulse, s_cmd_ready=1 after reset release.
